step_detector: RTL and testbench
================================

# step_detector

Pedometer step-detection stage, directly upstream of the weight/step register file. Consumes 8-bit acceleration-magnitude samples and the stored thresholds theta, beta and alpha. Low-pass filters the samples, detects peaks with hysteresis and debounce, and gates steps by inter-step interval. For each accepted step it emits a one-cycle `update_total_steps` pulse and `updated_steps`; the register file latches `updated_steps` into totalSteps on that pulse.

## Interface
- No parameters; all widths fixed at 8 bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  one new sample this cycle; the block ignores `sample` when low.
- sample  in  8  unsigned acceleration magnitude.
- theta_hi  in  8  peak-entry threshold (register file theta1).
- theta_lo  in  8  peak-exit threshold, hysteresis (register file theta2).
- beta_min  in  8  minimum samples between accepted steps (beta1).
- beta_max  in  8  gap, in samples, after which the walk expires (beta2).
- alpha_shift  in  8  EMA shift; only bits [2:0] are used (alpha1).
- alpha_debounce  in  8  consecutive samples at or above theta_hi needed to qualify a peak; 0 is treated as 1 (alpha2).
- total_steps_in  in  8  current totalSteps from the register file.
- updated_steps  out  8  registered; holds its value between pulses.
- update_total_steps  out  1  registered one-cycle pulse per accepted step.
- step_rejected  out  1  registered one-cycle pulse per peak rejected by beta_min.
- walk_active  out  1  registered; high while a walk is in progress.

## Operation
- All state advances only on cycles where `sample_valid` is high. On other cycles nothing changes, except that the output pulses drop to 0.
- EMA filter, `filt` (8 bits):
  - diff = {0,sample} − {0,filt}, a 9-bit signed value.
  - filt_next = filt + (diff >>> alpha_shift[2:0]), arithmetic shift, truncated to 8 bits.
  - With shift 0, filt_next = sample. The result never leaves 0..255.
- All threshold comparisons below use filt_next.
- Gap counter `gap` (8 bits):
  - g = min(gap+1, 255).
  - On accept, gap ← 0; otherwise gap ← g.
- Debounce count `cnt` (8 bits); D = max(alpha_debounce, 1).
- FSM states and transitions:
  - BELOW:
    - If filt_next ≥ theta_hi, set cnt ← 1.
    - If then 1 ≥ D, run the decision and go to PEAK; otherwise go to RISING.
    - Else stay in BELOW.
  - RISING:
    - If filt_next ≥ theta_hi, set cnt ← cnt+1; if cnt+1 ≥ D, run the decision and go to PEAK.
    - If filt_next < theta_hi, set cnt ← 0 and go to BELOW (the debounce run is broken).
  - PEAK:
    - If filt_next < theta_lo, set cnt ← 0 and go to BELOW.
    - Else stay in PEAK; no further decisions are made inside one peak.
- Decision, evaluated with the current g:
  - Accept if walk_active = 0 or g ≥ beta_min.
  - On accept:
    - update_total_steps ← 1.
    - updated_steps ← min(total_steps_in+1, 255).
    - walk_active ← 1.
    - gap ← 0.
  - On reject: step_rejected ← 1; gap ← g.
- Walk expiry: if there is no accept on this sample and g > beta_max, walk_active ← 0.
- Threshold and weight inputs are sampled live; a change takes effect on the next valid sample.
- theta_lo > theta_hi is legal and gives no hysteresis. PEAK exits on the first sample below theta_lo.

## Timing
- Reset values:
  - state BELOW; filt 0; cnt 0; gap 255; walk_active 0.
  - updated_steps 0; update_total_steps 0; step_rejected 0.
- Latency: a sample presented with `sample_valid` at edge N produces `update_total_steps` / `step_rejected` high for the single cycle following edge N. `updated_steps` is valid in that same cycle.
- The register file updates totalSteps at edge N+1, so `total_steps_in` reflects the new step 1 cycle after the pulse.
- Back-to-back valid samples every cycle are supported. Two accepts can never occur on consecutive samples, because a PEAK exit is required between them.
- Reset asserted mid-operation, in any state, overrides everything on that edge and discards any in-progress peak. No pulse is issued on the reset edge.
- `update_total_steps` and `step_rejected` are mutually exclusive in any cycle.

## Test plan
- Basic accept:
  - Stimulus: alpha_shift=0, alpha_debounce=1, theta_hi=100, theta_lo=60, beta_min=5, beta_max=50, total_steps_in=7; samples 0, 0, 120.
  - Required: update_total_steps pulses one cycle after the 120 sample; updated_steps=8; walk_active=1.
- Interval reject:
  - Stimulus: after the basic accept, samples 40, 120 (g=2 < 5).
  - Required: step_rejected pulse, no update pulse; then after 5 more low samples, a sample of 120 is accepted.
- EMA arithmetic:
  - Stimulus: alpha_shift=2, filt=0; samples 200, 200, 200.
  - Required: filt = 50, 87, 115; no step while filt < theta_hi=100; a step on the third sample.
- Debounce and hysteresis:
  - Stimulus: alpha_debounce=3, alpha_shift=0; samples 120, 120, 50, 120, 120, 120, 80, 120.
  - Required: exactly one accept, on the 6th sample. The 80 (≥ theta_lo) keeps PEAK, so the next 120 yields no step.
- Saturation and walk expiry:
  - Stimulus: total_steps_in=255 on accept; then 60 samples of 0 with beta_max=50, then 120.
  - Required: updated_steps=255 with a pulse; walk_active drops on the 51st sample; the later 120 is accepted regardless of beta_min.
- Reset mid-RISING:
  - Stimulus: alpha_debounce=3; samples 120, 120; reset for 1 cycle; then 120.
  - Required: all outputs 0 and gap=255 after reset; the post-reset 120 starts cnt at 1, with no pulse.

Source files
------------

// File: rtl/step_detector.sv
// step_detector: pedometer step-detection stage.
// EMA low-pass filter on the sample stream, peak detection with debounce on
// entry and hysteresis on exit, and an inter-step interval gate. Each accepted
// peak pulses update_total_steps with a saturated totalSteps+1.
module step_detector (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [7:0] theta_hi,
  input  logic [7:0] theta_lo,
  input  logic [7:0] beta_min,
  input  logic [7:0] beta_max,
  input  logic [7:0] alpha_shift,
  input  logic [7:0] alpha_debounce,
  input  logic [7:0] total_steps_in,
  output logic [7:0] updated_steps,
  output logic       update_total_steps,
  output logic       step_rejected,
  output logic       walk_active
);

  typedef enum logic [1:0] {BELOW, RISING, PEAK} state_t;

  state_t            state;
  logic        [7:0] filt;
  logic        [7:0] cnt;
  logic        [7:0] gap;

  logic signed [8:0] diff;
  logic signed [8:0] diff_sh;
  logic        [7:0] filt_next;
  logic        [7:0] g;
  logic        [7:0] deb;
  logic        [7:0] cnt_inc;
  logic        [7:0] steps_inc;
  logic              above_hi;
  logic              below_lo;
  logic              decide;
  logic              accept;

  // Only the low three bits of alpha_shift select the EMA shift.
  logic unused_alpha_bits;
  assign unused_alpha_bits = ^alpha_shift[7:3];

  // Next filter value, saturating gap, debounce target and the step decision.
  always_comb begin
    diff      = $signed({1'b0, sample}) - $signed({1'b0, filt});
    diff_sh   = diff >>> alpha_shift[2:0];
    // filt + shifted diff always lands in 0..255, so the low byte is exact.
    filt_next = filt + diff_sh[7:0];
    g         = (gap == 8'hFF) ? 8'hFF : gap + 8'd1;
    deb       = (alpha_debounce == 8'd0) ? 8'd1 : alpha_debounce;
    // cnt stays below deb while RISING, so this never wraps.
    cnt_inc   = cnt + 8'd1;
    steps_inc = (total_steps_in == 8'hFF) ? 8'hFF : total_steps_in + 8'd1;
    above_hi  = (filt_next >= theta_hi);
    below_lo  = (filt_next < theta_lo);
    decide    = 1'b0;
    case (state)
      BELOW:   decide = above_hi && (8'd1 >= deb);
      RISING:  decide = above_hi && (cnt_inc >= deb);
      default: decide = 1'b0;
    endcase
    accept    = decide && (!walk_active || (g >= beta_min));
  end

  // Peak FSM, filter, gap counter, walk tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= BELOW;
      filt               <= 8'd0;
      cnt                <= 8'd0;
      gap                <= 8'hFF;
      walk_active        <= 1'b0;
      updated_steps      <= 8'd0;
      update_total_steps <= 1'b0;
      step_rejected      <= 1'b0;
    end else begin
      update_total_steps <= 1'b0;
      step_rejected      <= 1'b0;
      if (sample_valid) begin
        filt <= filt_next;
        case (state)
          BELOW: begin
            if (above_hi) begin
              cnt   <= 8'd1;
              state <= decide ? PEAK : RISING;
            end
          end
          RISING: begin
            if (above_hi) begin
              cnt <= cnt_inc;
              if (decide) state <= PEAK;
            end else begin
              cnt   <= 8'd0;
              state <= BELOW;
            end
          end
          PEAK: begin
            if (below_lo) begin
              cnt   <= 8'd0;
              state <= BELOW;
            end
          end
          default: begin
            cnt   <= 8'd0;
            state <= BELOW;
          end
        endcase
        if (accept) begin
          update_total_steps <= 1'b1;
          updated_steps      <= steps_inc;
          walk_active        <= 1'b1;
          gap                <= 8'd0;
        end else begin
          gap <= g;
          if (decide)         step_rejected <= 1'b1;
          if (g > beta_max)   walk_active   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_detector.sv
// tb_step_detector: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the step rules.
module tb_step_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] theta_hi, theta_lo, beta_min, beta_max;
  logic [7:0] alpha_shift, alpha_debounce, total_steps_in;
  logic [7:0] updated_steps;
  logic       update_total_steps, step_rejected, walk_active;

  step_detector dut (
    .clk                (clk),
    .reset              (reset),
    .sample_valid       (sample_valid),
    .sample             (sample),
    .theta_hi           (theta_hi),
    .theta_lo           (theta_lo),
    .beta_min           (beta_min),
    .beta_max           (beta_max),
    .alpha_shift        (alpha_shift),
    .alpha_debounce     (alpha_debounce),
    .total_steps_in     (total_steps_in),
    .updated_steps      (updated_steps),
    .update_total_steps (update_total_steps),
    .step_rejected      (step_rejected),
    .walk_active        (walk_active)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state: filtered level, length of the current run above theta_hi,
  // whether we are inside a peak, samples since last step, walk flag
  int m_filt, m_run, m_gap;
  bit m_peak, m_walk;
  int e_upd, e_rej, e_us;
  bit pend;
  int pend_val;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_filt = 0; m_run = 0; m_gap = 255; m_peak = 0; m_walk = 0;
    e_upd = 0; e_rej = 0; e_us = 0;
  endtask

  task automatic mstep(input bit v, input int s);
    int f, g, d, sh;
    bit qualified;
    e_upd = 0;
    e_rej = 0;
    if (v) begin
      sh = int'(alpha_shift[2:0]);
      f  = m_filt + ((s - m_filt) >>> sh);
      m_filt = f;
      g  = (m_gap + 1 > 255) ? 255 : m_gap + 1;
      d  = (alpha_debounce == 0) ? 1 : int'(alpha_debounce);
      qualified = 0;
      if (m_peak) begin
        if (f < int'(theta_lo)) begin m_peak = 0; m_run = 0; end
      end else if (f >= int'(theta_hi)) begin
        m_run++;
        if (m_run >= d) begin qualified = 1; m_peak = 1; end
      end else begin
        m_run = 0;
      end
      if (qualified && (!m_walk || g >= int'(beta_min))) begin
        e_upd  = 1;
        e_us   = (int'(total_steps_in) + 1 > 255) ? 255 : int'(total_steps_in) + 1;
        m_walk = 1;
        m_gap  = 0;
      end else begin
        m_gap = g;
        if (qualified) e_rej = 1;
        if (g > int'(beta_max)) m_walk = 0;
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".upd"},  int'(update_total_steps), e_upd);
    chk({tag, ".rej"},  int'(step_rejected),      e_rej);
    chk({tag, ".us"},   int'(updated_steps),      e_us);
    chk({tag, ".walk"}, int'(walk_active),        int'(m_walk));
  endtask

  // One clock with the given sample; the bench plays the register file,
  // latching updated_steps into total_steps_in one edge after the pulse.
  task automatic step(input bit v, input int s);
    sample_valid = v;
    sample       = 8'(s);
    @(posedge clk); #1;
    mstep(v, s);
    if (pend) begin total_steps_in = 8'(pend_val); pend = 0; end
    compare("cyc");
    if (e_upd != 0) begin pend = 1; pend_val = e_us; end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'($urandom_range(0, 1));
    sample       = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    reset = 1'b0;
    mreset();
    pend = 0;
    compare("rst");
  endtask

  initial begin
    int n, idx, drop, level;
    int seq [8];
    reset = 1'b0; sample_valid = 1'b0; sample = 8'd0;
    theta_hi = 8'd100; theta_lo = 8'd60; beta_min = 8'd5; beta_max = 8'd50;
    alpha_shift = 8'd0; alpha_debounce = 8'd1; total_steps_in = 8'd7;
    pend = 0; pend_val = 0;
    mreset();
    do_reset();
    chk("rst_us", int'(updated_steps), 0);
    chk("rst_walk", int'(walk_active), 0);

    // basic accept
    step(1, 0); step(1, 0); step(1, 120);
    chk("basic_upd", int'(update_total_steps), 1);
    chk("basic_us", int'(updated_steps), 8);
    chk("basic_walk", int'(walk_active), 1);

    // interval reject, then accept after enough low samples
    step(1, 40); step(1, 120);
    chk("ivl_rej", int'(step_rejected), 1);
    chk("ivl_noupd", int'(update_total_steps), 0);
    repeat (5) step(1, 40);
    step(0, 200);
    chk("idle_noupd", int'(update_total_steps), 0);
    step(1, 120);
    chk("ivl_acc", int'(update_total_steps), 1);
    chk("ivl_us", int'(updated_steps), 9);

    // EMA with shift 2: filt 50, 87, 115
    do_reset();
    alpha_shift = 8'd2;
    step(1, 200); chk("ema1", int'(update_total_steps), 0);
    step(1, 200); chk("ema2", int'(update_total_steps), 0);
    step(1, 200); chk("ema3", int'(update_total_steps), 1);

    // debounce 3 and hysteresis
    do_reset();
    alpha_shift = 8'd0; alpha_debounce = 8'd3;
    seq = '{120, 120, 50, 120, 120, 120, 80, 120};
    n = 0; idx = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i]);
      if (update_total_steps) begin n++; idx = i + 1; end
    end
    chk("deb_cnt", n, 1);
    chk("deb_idx", idx, 6);

    // saturation and walk expiry
    do_reset();
    alpha_debounce = 8'd1; total_steps_in = 8'd255; beta_max = 8'd50;
    step(1, 120);
    chk("sat_upd", int'(update_total_steps), 1);
    chk("sat_us", int'(updated_steps), 255);
    drop = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1, 0);
      if (!walk_active && drop == 0) drop = i;
    end
    chk("walk_drop", drop, 51);
    beta_min = 8'd200;
    step(1, 120);
    chk("expired_acc", int'(update_total_steps), 1);

    // reset in the middle of a debounce run
    beta_min = 8'd5; total_steps_in = 8'd3; alpha_debounce = 8'd3;
    do_reset();
    step(1, 120); step(1, 120);
    do_reset();
    chk("mid_rst_walk", int'(walk_active), 0);
    step(1, 120); chk("post_rst1", int'(update_total_steps), 0);
    step(1, 120); chk("post_rst2", int'(update_total_steps), 0);
    step(1, 120); chk("post_rst3", int'(update_total_steps), 1);
    chk("post_rst_us", int'(updated_steps), 4);

    // randomized traffic
    level = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        theta_hi       = 8'($urandom_range(60, 200));
        theta_lo       = 8'($urandom_range(20, 220));
        beta_min       = 8'($urandom_range(0, 20));
        beta_max       = 8'($urandom_range(0, 40));
        alpha_shift    = 8'($urandom_range(0, 3)) | 8'($urandom_range(0, 31) << 3);
        alpha_debounce = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 99) == 0) total_steps_in = 8'($urandom_range(240, 255));
      if ($urandom_range(0, 5) == 0) level = 1 - level;
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0),
                level != 0 ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 80)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
